tone_player: RTL and testbench

Audio tone generator on the consumer side of the game's sound-trigger interface. While `sound_flag` is high, it plays a square-wave tone at the frequency given on `sound_freq`, in Hz. Amplitude ramps up linearly on attack and down linearly on release, which prevents audible clicks. Signed 16-bit samples are delivered to the audio codec interface using a per-sample request/valid handshake.

---
 rtl/sound_pkg.sv | 20 ++
 rtl/tone_nco.sv | 43 ++++
 rtl/tone_player.sv | 134 +++++++++++++
 tb/tb_tone_player.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sound_pkg : shared types and constants for the sound-trigger path
// Rev 1.0
// ---------------------------------------------------------------------------
package sound_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ATTACK  = 2'd1,
      SUSTAIN = 2'd2,
      RELEASE = 2'd3
   } tone_state_t;

   localparam int CLK_HZ   = 50_000_000;
   localparam int SAMPLE_W = 16;
   localparam int PHASE_W  = 32;

endpackage
`default_nettype wire

// File: rtl/tone_nco.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_nco : phase accumulator with latched increment; sq_out is the phase MSB
// Rev 1.0
// ---------------------------------------------------------------------------
module tone_nco
   import sound_pkg::*;
#(
   parameter int PHASE_INC_PER_HZ = 86
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       load,
   input  logic       clear,
   input  logic       run,
   input  logic [9:0] freq,
   output logic       sq_out
);

   logic [PHASE_W-1:0] r_inc;
   logic [PHASE_W-1:0] r_phase;

   // Clear wins over run so a fresh tone always starts at phase 0.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_inc   <= '0;
         r_phase <= '0;
      end else begin
         if (load) begin
            r_inc <= PHASE_W'(freq) * PHASE_W'(PHASE_INC_PER_HZ);
         end
         if (clear) begin
            r_phase <= '0;
         end else if (run) begin
            r_phase <= r_phase + r_inc;
         end
      end
   end

   assign sq_out = r_phase[PHASE_W-1];

endmodule
`default_nettype wire

// File: rtl/tone_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tone_player : square-wave tone with linear attack/release envelope
// Rev 1.0
// ---------------------------------------------------------------------------
module tone_player
   import sound_pkg::*;
#(
   parameter int PHASE_INC_PER_HZ = 86,
   parameter int AMP_MAX          = 8192,
   parameter int AMP_STEP         = 64
) (
   input  logic                clk,
   input  logic                resetN,
   input  logic                sound_flag,
   input  logic [9:0]          sound_freq,
   input  logic                sample_req,
   output logic                sample_valid,
   output logic [SAMPLE_W-1:0] sample_data,
   output logic                busy
);

   localparam logic [14:0] C_AMP_MAX  = 15'(AMP_MAX);
   localparam logic [14:0] C_AMP_STEP = 15'(AMP_STEP);

   tone_state_t         r_state;
   tone_state_t         w_state_nxt;
   logic [14:0]         r_amp;
   logic [14:0]         w_amp_nxt;
   logic                r_flag_d;
   logic                w_rise;
   logic                w_freq_nz;
   logic                w_load;
   logic                w_clear;
   logic                w_sq;
   logic [15:0]         w_amp_sum;
   logic [14:0]         w_amp_up;
   logic [14:0]         w_amp_dn;
   logic [SAMPLE_W-1:0] w_mag;
   logic [SAMPLE_W-1:0] w_sample;

   assign w_rise    = sound_flag & ~r_flag_d;
   assign w_freq_nz = |sound_freq;

   // Saturating envelope steps; the 16-bit sum keeps the overflow visible.
   assign w_amp_sum = {1'b0, r_amp} + {1'b0, C_AMP_STEP};
   assign w_amp_up  = (w_amp_sum >= {1'b0, C_AMP_MAX}) ? C_AMP_MAX : w_amp_sum[14:0];
   assign w_amp_dn  = (r_amp > C_AMP_STEP) ? (r_amp - C_AMP_STEP) : '0;

   assign w_mag    = {1'b0, r_amp};
   assign w_sample = (r_state == IDLE) ? '0 : (w_sq ? -w_mag : w_mag);

   always_comb begin
      w_state_nxt = r_state;
      w_amp_nxt   = r_amp;
      w_load      = 1'b0;
      w_clear     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_rise && w_freq_nz) begin
               w_load      = 1'b1;
               w_clear     = 1'b1;
               w_state_nxt = ATTACK;
            end
         end
         ATTACK: begin
            if (sample_req) begin
               w_amp_nxt = w_amp_up;
               if (w_amp_up == C_AMP_MAX) begin
                  w_state_nxt = SUSTAIN;
               end
            end
            if (!sound_flag) begin
               w_state_nxt = RELEASE;
            end
         end
         SUSTAIN: begin
            if (!sound_flag) begin
               w_state_nxt = RELEASE;
            end
         end
         RELEASE: begin
            if (sample_req) begin
               w_amp_nxt = w_amp_dn;
               if (w_amp_dn == '0) begin
                  w_state_nxt = IDLE;
               end
            end
            // A re-trigger resumes the ramp from the current amplitude and phase.
            if (w_rise && w_freq_nz) begin
               w_load      = 1'b1;
               w_state_nxt = ATTACK;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state      <= IDLE;
         r_amp        <= '0;
         r_flag_d     <= 1'b0;
         sample_valid <= 1'b0;
         sample_data  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_amp        <= w_amp_nxt;
         r_flag_d     <= sound_flag;
         sample_valid <= sample_req;
         if (sample_req) begin
            sample_data <= w_sample;
         end
      end
   end

   assign busy = (r_state != IDLE);

   tone_nco #(
      .PHASE_INC_PER_HZ(PHASE_INC_PER_HZ)
   ) u_nco (
      .clk    (clk),
      .resetN (resetN),
      .load   (w_load),
      .clear  (w_clear),
      .run    (busy),
      .freq   (sound_freq),
      .sq_out (w_sq)
   );

endmodule
`default_nettype wire

// File: tb/tb_tone_player.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tone_player : scoreboard bench for tone_player (attack, sustain, release, re-trigger)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_tone_player;
   import sound_pkg::*;

   logic        clk = 1'b0;
   logic        resetN;
   logic        sound_flag;
   logic [9:0]  sound_freq;
   logic        sample_req;
   logic        sample_valid;
   logic [15:0] sample_data;
   logic        busy;

   int          checks   = 0;
   int          failures = 0;
   longint      cyc      = 0;
   longint      t0       = 0;
   longint      tr       = 0;
   longint      inc1     = 0;
   longint      inc2     = 0;
   bit          has_rr   = 1'b0;
   logic [15:0] exp_q[$];

   tone_player dut (
      .clk          (clk),
      .resetN       (resetN),
      .sound_flag   (sound_flag),
      .sound_freq   (sound_freq),
      .sample_req   (sample_req),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .busy         (busy)
   );

   always #10 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Phase seen by a request raised now: cleared at posedge t0, one increment per clk,
   // the re-trigger posedge tr still adds the old increment.
   function automatic logic [15:0] expect_sample(input int amp, input bit idle);
      longint      p;
      logic [31:0] ph;
      if (idle) return 16'h0000;
      if (!has_rr || cyc <= tr) p = (cyc - t0) * inc1;
      else                      p = (tr - t0) * inc1 + (cyc - tr) * inc2;
      ph = p[31:0];
      return ph[31] ? -16'(amp) : 16'(amp);
   endfunction

   task automatic issue(input int amp, input bit idle);
      sample_req = 1'b1;
      exp_q.push_back(expect_sample(amp, idle));
      @(negedge clk);
   endtask

   task automatic req_gap(input int amp, input bit idle, input int gap);
      issue(amp, idle);
      sample_req = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   initial begin : monitor
      logic [15:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (sample_valid || sample_req) begin
            checks++;
            if (sample_valid !== sample_req) begin
               failures++;
               $display("FAIL valid_timing: sample_valid=%b, expected %b", sample_valid, sample_req);
            end
         end
         if (sample_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_valid: sample_data=%0d with no request pending", $signed(sample_data));
            end else begin
               e = exp_q.pop_front();
               if (sample_data !== e) begin
                  failures++;
                  $display("FAIL sample_data: got %0d, expected %0d", $signed(sample_data), $signed(e));
               end
            end
         end
      end
   end

   initial begin
      #(200_000 * 20);
      $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "time limit");
   end

   initial begin
      resetN     = 1'b0;
      sound_flag = 1'b0;
      sound_freq = '0;
      sample_req = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid", sample_valid, 0);
      check("rst_data", sample_data, 0);
      check("rst_busy", busy, 0);
      resetN = 1'b1;
      @(negedge clk);

      req_gap(0, 1, 2);

      // Zero frequency never leaves IDLE
      sound_flag = 1'b1;
      sound_freq = 10'd0;
      @(negedge clk);
      check("busy_freq0", busy, 0);
      req_gap(0, 1, 1);
      req_gap(0, 1, 2);
      check("state_freq0", dut.r_state, IDLE);
      sound_flag = 1'b0;
      @(negedge clk);

      // 440 Hz start, with a request in the start cycle
      sound_flag = 1'b1;
      sound_freq = 10'd440;
      t0         = cyc + 1;
      inc1       = 37840;
      has_rr     = 1'b0;
      issue(0, 1);
      sample_req = 1'b0;
      check("busy_rise", busy, 1);
      check("inc_440", dut.u_nco.r_inc, 37840);
      for (int j = 0; j < 128; j++) begin
         if (j == 127) check("attack_before_last", dut.r_state, ATTACK);
         req_gap(64 * j, 0, 3);
      end
      check("sustain_state", dut.r_state, SUSTAIN);
      check("amp_max", dut.r_amp, 8192);
      req_gap(8192, 0, 4);
      check("data_hold", sample_data, 8192);
      check("valid_low", sample_valid, 0);

      // Back-to-back requests across the first phase[31] transition (k=56751 -> 56752)
      while (cyc - t0 < 56750) @(negedge clk);
      issue(8192, 0);
      issue(8192, 0);
      issue(8192, 0);
      sample_req = 1'b0;
      check("sign_flip", sample_data, 16'hE000);

      // Release to 4096; frequency changes while active are ignored
      sound_freq = 10'd100;
      sound_flag = 1'b0;
      @(negedge clk);
      check("release_state", dut.r_state, RELEASE);
      for (int j = 0; j < 64; j++) req_gap(8192 - 64 * j, 0, 3);
      check("amp_4096", dut.r_amp, 4096);

      // Re-trigger at 880 Hz from RELEASE
      sound_flag = 1'b1;
      sound_freq = 10'd880;
      tr         = cyc + 1;
      inc2       = 75680;
      has_rr     = 1'b1;
      @(negedge clk);
      check("reattack_state", dut.r_state, ATTACK);
      check("inc_880", dut.u_nco.r_inc, 75680);
      check("amp_kept", dut.r_amp, 4096);
      for (int j = 0; j < 64; j++) req_gap(4096 + 64 * j, 0, 3);
      check("resustain", dut.r_state, SUSTAIN);

      // Full release to silence
      sound_freq = 10'd5;
      sound_flag = 1'b0;
      @(negedge clk);
      for (int j = 0; j < 128; j++) req_gap(8192 - 64 * j, 0, 3);
      check("idle_after_release", dut.r_state, IDLE);
      check("busy_off", busy, 0);
      check("inc_not_relatched", dut.u_nco.r_inc, 75680);
      req_gap(0, 1, 2);

      // Asynchronous reset mid-sustain
      sound_freq = 10'd440;
      sound_flag = 1'b1;
      t0         = cyc + 1;
      has_rr     = 1'b0;
      @(negedge clk);
      for (int j = 0; j < 128; j++) req_gap(64 * j, 0, 1);
      issue(8192, 0);
      sample_req = 1'b0;
      check("pre_reset_valid", sample_valid, 1);
      check("pre_reset_busy", busy, 1);
      #1 resetN = 1'b0;
      #1;
      check("async_valid", sample_valid, 0);
      check("async_data", sample_data, 0);
      check("async_busy", busy, 0);
      @(negedge clk);
      resetN     = 1'b1;
      sound_flag = 1'b0;
      repeat (2) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
